// File: rtl/pio_clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// pio_clkdiv_pkg
// Shared constants, types and helpers for the PIO clock-enable scheduler.
//   NUM_SM_MAX  : largest supported number of state machines
//   CFG_INT_W   : integer divider field width
//   CFG_FRAC_W  : fractional divider field width (1/256 steps)
//   DIV_W       : width of the effective divisor and of the phase accumulator
//   ACC_STEP    : amount the accumulator advances per enabled cycle (1.0)
//   DIV_RESET   : effective divisor after reset (1.0)
//   clkdiv_cfg_t: {int_part, frac_part} as written by the register file
// Optional feature macro used by the files that import this package:
//   PIO_CLKDIV_READBACK_EN
// ---------------------------------------------------------------------------
package pio_clkdiv_pkg;

    localparam int NUM_SM_MAX = 16;
    localparam int CFG_INT_W  = 16;
    localparam int CFG_FRAC_W = 8;
    localparam int DIV_W      = 25;

    localparam logic [DIV_W-1:0] ACC_STEP  = 25'd256;
    localparam logic [DIV_W-1:0] DIV_RESET = {17'd1, 8'd0};

    typedef struct packed {
        logic [CFG_INT_W-1:0]  int_part;
        logic [CFG_FRAC_W-1:0] frac_part;
    } clkdiv_cfg_t;

    // An integer part of zero stands for 65536, so the divisor is never below 1.0.
    function automatic logic [DIV_W-1:0] eff_divisor(input clkdiv_cfg_t cfg);
        logic [CFG_INT_W:0] int_eff;
        int_eff = (cfg.int_part == '0) ? 17'h10000 : {1'b0, cfg.int_part};
        return {int_eff, cfg.frac_part};
    endfunction

endpackage

// File: rtl/pio_clkdiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// pio_clkdiv_ctrl_if
// Groups the control/status signals of pio_clkdiv_ctrl.
//   sm_en    : per-SM run enable
//   restart  : per-SM one-cycle phase restart
//   cfg_we   : divider write strobe (one cycle)
//   cfg_sel  : target SM of cfg_we, also the readback select
//   cfg_int  : integer part of the divider (0 means 65536)
//   cfg_frac : fractional part of the divider
//   penable  : registered per-SM execute strobe
//   rd_int / rd_frac / rd_pend : active divider and pending flag of cfg_sel
//                                (present only with PIO_CLKDIV_READBACK_EN)
// Modports: master drives control and reads status, slave is the scheduler.
// ---------------------------------------------------------------------------
interface pio_clkdiv_ctrl_if #(
    parameter int NUM_SM = 4
);
    import pio_clkdiv_pkg::*;

    localparam int SEL_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

    logic [NUM_SM-1:0]     sm_en;
    logic [NUM_SM-1:0]     restart;
    logic                  cfg_we;
    logic [SEL_W-1:0]      cfg_sel;
    logic [CFG_INT_W-1:0]  cfg_int;
    logic [CFG_FRAC_W-1:0] cfg_frac;
    logic [NUM_SM-1:0]     penable;
`ifdef PIO_CLKDIV_READBACK_EN
    logic [CFG_INT_W-1:0]  rd_int;
    logic [CFG_FRAC_W-1:0] rd_frac;
    logic                  rd_pend;
`endif

    modport master (
        output sm_en,
        output restart,
        output cfg_we,
        output cfg_sel,
        output cfg_int,
        output cfg_frac,
`ifdef PIO_CLKDIV_READBACK_EN
        input  rd_int,
        input  rd_frac,
        input  rd_pend,
`endif
        input  penable
    );

    modport slave (
        input  sm_en,
        input  restart,
        input  cfg_we,
        input  cfg_sel,
        input  cfg_int,
        input  cfg_frac,
`ifdef PIO_CLKDIV_READBACK_EN
        output rd_int,
        output rd_frac,
        output rd_pend,
`endif
        output penable
    );

endinterface

// File: rtl/pio_fracdiv_ch.sv
// ---------------------------------------------------------------------------
// pio_fracdiv_ch
// One fractional clock-enable channel: phase accumulator, active divisor,
// pending divisor and the rule that moves pending into active.
//   clk, reset  : clock, synchronous active-high reset
//   sm_en       : run enable of this SM
//   restart     : clear the phase accumulator this cycle
//   wr_en       : load wr_cfg into the pending register
//   wr_cfg      : divider value being written
//   active_cfg  : active divider as {int, frac} (PIO_CLKDIV_READBACK_EN only)
//   pend_out    : pending flag (PIO_CLKDIV_READBACK_EN only)
//   penable     : registered execute strobe
// ---------------------------------------------------------------------------
module pio_fracdiv_ch
    import pio_clkdiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sm_en,
    input  logic        restart,
    input  logic        wr_en,
    input  clkdiv_cfg_t wr_cfg,
`ifdef PIO_CLKDIV_READBACK_EN
    output clkdiv_cfg_t active_cfg,
    output logic        pend_out,
`endif
    output logic        penable
);

    logic [DIV_W-1:0] acc;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] step_sum;
    clkdiv_cfg_t      pend_cfg;
    logic             pend_flag;
    logic             tick;
    logic             apply_now;

    // acc stays below div_q, so acc + 1.0 always fits in DIV_W bits.
    // A write in the same cycle as an apply opportunity wins over the apply,
    // so the new value waits for the next opportunity.
    always_comb begin
        step_sum  = acc + ACC_STEP;
        tick      = sm_en && !restart && (step_sum >= div_q);
        apply_now = pend_flag && !wr_en && (tick || !sm_en || restart);
    end

    // The tick cycle still uses the old divisor for its own accumulator
    // update; only the following period sees the newly applied divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            div_q     <= DIV_RESET;
            pend_cfg  <= '0;
            pend_flag <= 1'b0;
            penable   <= 1'b0;
        end else begin
            if (restart) begin
                acc     <= '0;
                penable <= 1'b0;
            end else if (sm_en) begin
                acc     <= tick ? (step_sum - div_q) : step_sum;
                penable <= tick;
            end else begin
                penable <= 1'b0;
            end

            if (wr_en) begin
                pend_cfg  <= wr_cfg;
                pend_flag <= 1'b1;
            end else if (apply_now) begin
                div_q     <= eff_divisor(pend_cfg);
                pend_flag <= 1'b0;
            end
        end
    end

`ifdef PIO_CLKDIV_READBACK_EN
    // Dropping the top bit maps an effective 65536 back to the written 0.
    assign active_cfg = clkdiv_cfg_t'(div_q[CFG_INT_W+CFG_FRAC_W-1:0]);
    assign pend_out   = pend_flag;
`endif

endmodule

// File: rtl/pio_clkdiv_ctrl.sv
// ---------------------------------------------------------------------------
// pio_clkdiv_ctrl
// Clock-enable scheduler for the BIO/PIO state machines. Holds one fractional
// divider per SM, applies divider writes only on tick boundaries, supports a
// masked phase restart and drives the per-SM penable strobes.
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : pio_clkdiv_ctrl_if slave modport (sm_en, restart, cfg_*, penable,
//            and rd_int/rd_frac/rd_pend when PIO_CLKDIV_READBACK_EN is defined)
// Parameters:
//   NUM_SM : number of state machines; must match the interface instance.
// Divider field widths come from pio_clkdiv_pkg (16-bit int, 8-bit frac).
// Optional feature: PIO_CLKDIV_READBACK_EN adds combinational readback of the
// active divider and pending flag of cfg_sel.
// ---------------------------------------------------------------------------
module pio_clkdiv_ctrl
    import pio_clkdiv_pkg::*;
#(
    parameter int NUM_SM = 4
) (
    input  logic             clk,
    input  logic             reset,
    pio_clkdiv_ctrl_if.slave bus
);

    localparam int SEL_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

    clkdiv_cfg_t       wr_cfg;
    logic [NUM_SM-1:0] penable_vec;
`ifdef PIO_CLKDIV_READBACK_EN
    clkdiv_cfg_t       active_cfg [NUM_SM];
    logic [NUM_SM-1:0] pend_vec;
`endif

    always_comb begin
        wr_cfg.int_part  = bus.cfg_int;
        wr_cfg.frac_part = bus.cfg_frac;
    end

    for (genvar i = 0; i < NUM_SM; i++) begin : g_ch
        logic wr_en_ch;
        assign wr_en_ch = bus.cfg_we && (bus.cfg_sel == SEL_W'(i));

        pio_fracdiv_ch u_ch (
            .clk        (clk),
            .reset      (reset),
            .sm_en      (bus.sm_en[i]),
            .restart    (bus.restart[i]),
            .wr_en      (wr_en_ch),
            .wr_cfg     (wr_cfg),
`ifdef PIO_CLKDIV_READBACK_EN
            .active_cfg (active_cfg[i]),
            .pend_out   (pend_vec[i]),
`endif
            .penable    (penable_vec[i])
        );
    end

    assign bus.penable = penable_vec;

`ifdef PIO_CLKDIV_READBACK_EN
    always_comb begin
        bus.rd_int  = active_cfg[bus.cfg_sel].int_part;
        bus.rd_frac = active_cfg[bus.cfg_sel].frac_part;
        bus.rd_pend = pend_vec[bus.cfg_sel];
    end
`endif

endmodule

// File: tb/tb_pio_clkdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pio_clkdiv_ctrl
// Self-checking bench for pio_clkdiv_ctrl with NUM_SM = 4. Every cycle the
// DUT penable is compared with a reference model that tracks each SM's phase
// in 1/256 cycle units. Directed table vectors and hand sequences cover the
// divider-apply timing, fractional periods, restart alignment and the 65536
// divisor; a randomized run closes out the test.
// ---------------------------------------------------------------------------
module tb_pio_clkdiv_ctrl;
    import pio_clkdiv_pkg::*;

    localparam int NUM_SM = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pio_clkdiv_ctrl_if #(.NUM_SM(NUM_SM)) bus ();

    pio_clkdiv_ctrl #(.NUM_SM(NUM_SM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase in 1/256 cycles, divisors as plain integers.
    int   m_phase  [NUM_SM];
    int   m_div    [NUM_SM];
    int   m_next   [NUM_SM];
    bit   m_waiting[NUM_SM];
    logic [NUM_SM-1:0] m_pen;

    typedef struct {
        logic [3:0]  en;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] ival;
        logic [7:0]  fval;
        logic [3:0]  rst;
        logic [3:0]  exp_pen;
    } vec_t;

    vec_t vecs[14];

    function automatic int divisorOf(input logic [15:0] iv, input logic [7:0] fv);
        int whole;
        whole = (iv == 16'd0) ? 65536 : int'(iv);
        return whole * 256 + int'(fv);
    endfunction

    // One clock of the reference model, given the inputs present at the edge.
    function automatic void modelStep(input logic [3:0] en, input logic we,
                                      input logic [1:0] sel, input logic [15:0] iv,
                                      input logic [7:0] fv, input logic [3:0] rs,
                                      input logic rst);
        for (int i = 0; i < NUM_SM; i++) begin
            bit boundary;
            if (rst) begin
                m_phase[i]   = 0;
                m_div[i]     = 256;
                m_next[i]    = 0;
                m_waiting[i] = 0;
                m_pen[i]     = 1'b0;
            end else begin
                boundary = 0;
                if (rs[i]) begin
                    m_phase[i] = 0;
                    m_pen[i]   = 1'b0;
                    boundary   = 1;
                end else if (!en[i]) begin
                    m_pen[i] = 1'b0;
                    boundary = 1;
                end else begin
                    m_phase[i] += 256;
                    m_pen[i] = (m_phase[i] >= m_div[i]);
                    if (m_pen[i]) begin
                        m_phase[i] -= m_div[i];
                        boundary = 1;
                    end
                end
                if (we && (int'(sel) == i)) begin
                    m_next[i]    = divisorOf(iv, fv);
                    m_waiting[i] = 1;
                end else if (m_waiting[i] && boundary) begin
                    m_div[i]     = m_next[i];
                    m_waiting[i] = 0;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample #1 after the edge.
    task automatic applyStimulus(input logic [3:0] en, input logic we,
                                 input logic [1:0] sel, input logic [15:0] iv,
                                 input logic [7:0] fv, input logic [3:0] rs,
                                 input logic rst);
        bus.sm_en    = en;
        bus.cfg_we   = we;
        bus.cfg_sel  = sel;
        bus.cfg_int  = iv;
        bus.cfg_frac = fv;
        bus.restart  = rs;
        reset        = rst;
        @(posedge clk);
        modelStep(en, we, sel, iv, fv, rs, rst);
        #1;
        checkOutput("model_penable", 32'(bus.penable), 32'(m_pen));
    endtask

    task automatic idleCycle(input logic [3:0] en);
        applyStimulus(en, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 1'b0);
    endtask

    initial begin
        int ticks;
        int last;
        int bad;
        int early;
        logic [3:0] rs;

        // Divider 1.0 start-up, then 2.0 written to SM0 while running.
        vecs[0]  = '{4'b0000, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1111};
        vecs[2]  = '{4'b1111, 1'b1, 2'd0, 16'd2, 8'd0, 4'b0000, 4'b1111};
        vecs[3]  = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1111};
        vecs[4]  = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1110};
        vecs[5]  = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1111};
        vecs[6]  = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1110};
        vecs[7]  = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1111};
        vecs[8]  = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0001, 4'b1110};
        vecs[9]  = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1110};
        vecs[10] = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1111};
        vecs[11] = '{4'b0000, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b0000};
        vecs[12] = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1110};
        vecs[13] = '{4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 4'b1111};

        $display("[TB] reset");
        applyStimulus(4'b0000, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 1'b1);
        checkOutput("reset_penable", 32'(bus.penable), 32'h0);

        $display("[TB] table vectors");
        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].en, vecs[v].we, vecs[v].sel, vecs[v].ival,
                          vecs[v].fval, vecs[v].rst, 1'b0);
            checkOutput($sformatf("table_row%0d", v), 32'(bus.penable), 32'(vecs[v].exp_pen));
        end

        // SM1 to 2.5: gaps 3,2,3,2,... after restart and 40 ticks per 100 cycles.
        $display("[TB] fractional 2.5 on SM1");
        applyStimulus(4'b1111, 1'b1, 2'd1, 16'd2, 8'd128, 4'b0000, 1'b0);
        idleCycle(4'b1111);
        applyStimulus(4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0010, 1'b0);
        ticks = 0;
        last  = 0;
        bad   = 0;
        for (int c = 1; c <= 100; c++) begin
            idleCycle(4'b1111);
            if (bus.penable[1]) begin
                if ((c - last) != ((ticks % 2 == 0) ? 3 : 2)) bad++;
                ticks++;
                last = c;
            end
        end
        checkOutput("frac_2p5_tick_count", 32'(ticks), 32'd40);
        checkOutput("frac_2p5_gap_errors", 32'(bad), 32'd0);

        // SM0 and SM1 to 3.0 at different times, then a joint restart.
        $display("[TB] restart alignment");
        applyStimulus(4'b1111, 1'b1, 2'd0, 16'd3, 8'd0, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 1'b1, 2'd1, 16'd3, 8'd0, 4'b0000, 1'b0);
        for (int c = 0; c < 10; c++) idleCycle(4'b1111);
        applyStimulus(4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0011, 1'b0);
        checkOutput("restart_cycle_pen", 32'(bus.penable[1:0]), 32'h0);
        for (int c = 1; c <= 9; c++) begin
            idleCycle(4'b1111);
            checkOutput($sformatf("aligned_c%0d", c), 32'(bus.penable[1:0]),
                        (c % 3 == 0) ? 32'h3 : 32'h0);
        end

        // SM3: 4.0 then 5.0 back to back, last write wins.
        $display("[TB] last write wins and write in tick cycle");
        applyStimulus(4'b1111, 1'b1, 2'd3, 16'd4, 8'd0, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 1'b1, 2'd3, 16'd5, 8'd0, 4'b0000, 1'b0);
        idleCycle(4'b1111);
        applyStimulus(4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b1000, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            if (c == 5) applyStimulus(4'b1111, 1'b1, 2'd3, 16'd2, 8'd0, 4'b0000, 1'b0);
            else        idleCycle(4'b1111);
            checkOutput($sformatf("sm3_c%0d", c), 32'(bus.penable[3]),
                        (c == 5 || c == 10 || c == 12 || c == 14) ? 32'd1 : 32'd0);
        end

        // SM2 to int=0, i.e. 65536 cycles per tick, then reset mid-count.
        $display("[TB] divisor 65536 on SM2");
        applyStimulus(4'b1111, 1'b1, 2'd2, 16'd0, 8'd0, 4'b0000, 1'b0);
        idleCycle(4'b1111);
        applyStimulus(4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0100, 1'b0);
        early = 0;
        for (int c = 1; c < 65536; c++) begin
            idleCycle(4'b1111);
            if (bus.penable[2]) early++;
        end
        checkOutput("int0_no_early_tick", 32'(early), 32'd0);
        idleCycle(4'b1111);
        checkOutput("int0_first_tick", 32'(bus.penable[2]), 32'd1);
        for (int c = 0; c < 100; c++) idleCycle(4'b1111);
        applyStimulus(4'b1111, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0000, 1'b1);
        checkOutput("reset_mid_penable", 32'(bus.penable), 32'h0);
        idleCycle(4'b1111);
        checkOutput("post_reset_div1_a", 32'(bus.penable), 32'hF);
        idleCycle(4'b1111);
        checkOutput("post_reset_div1_b", 32'(bus.penable), 32'hF);

        // Randomized mix of enables, restarts and writes against the model.
        $display("[TB] random run");
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] en;
            for (int i = 0; i < NUM_SM; i++) begin
                en[i] = ($urandom_range(0, 9) != 0);
                rs[i] = ($urandom_range(0, 39) == 0);
            end
            applyStimulus(en, ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
                          16'($urandom_range(1, 6)), 8'($urandom_range(0, 255)), rs, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
